pcs_cacheline_adapter: RTL



---
 rtl/pcs_cacheline_adapter_pkg.sv | 14 +
 rtl/pcs_cacheline_adapter_if.sv | 35 +++
 rtl/pcs_cacheline_adapter_line_deser.sv | 45 ++++
 rtl/pcs_cacheline_adapter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pcs_cacheline_adapter_pkg.sv
// Shared types for the cache-line <-> burst-memory adapter.
package pcs_cacheline_adapter_pkg;

    localparam int PCS_BEATS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_BURST,
        RD_REQ,
        RD_WAIT,
        RESP
    } adapter_state_t;

endpackage

// File: rtl/pcs_cacheline_adapter_if.sv
// Cache-side and burst-memory-side signals of the line adapter.
// slave = adapter view, master = cache plus burst memory.
interface pcs_cacheline_adapter_if #(
    parameter int CACHE_LINE_SIZE = 256,
    parameter int BURST_WIDTH     = 64,
    parameter int ADDR_WIDTH      = 32
);
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic                       mem_read;
    logic                       mem_write;
    logic [CACHE_LINE_SIZE-1:0] mem_line_wb;
    logic [CACHE_LINE_SIZE-1:0] mem_rdata;
    logic                       mem_resp;
    logic [ADDR_WIDTH-1:0]      bmem_addr;
    logic                       bmem_read;
    logic                       bmem_write;
    logic [BURST_WIDTH-1:0]     bmem_wdata;
    logic                       bmem_ready;
    logic [BURST_WIDTH-1:0]     bmem_rdata;
    logic                       bmem_rvalid;

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_line_wb,
        input  bmem_ready, bmem_rdata, bmem_rvalid,
        output mem_rdata, mem_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output mem_addr, mem_read, mem_write, mem_line_wb,
        output bmem_ready, bmem_rdata, bmem_rvalid,
        input  mem_rdata, mem_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/pcs_cacheline_adapter_line_deser.sv
// Beat-indexed line buffer plus beat counter; holds the write line for slice
// selection or collects read beats.
module pcs_line_deser #(
    parameter int BEATS       = 4,
    parameter int BURST_WIDTH = 64
) (
    input  logic                         gclk,
    input  logic                         grst_n,
    input  logic                         i_clr,
    input  logic                         i_load,
    input  logic [BEATS*BURST_WIDTH-1:0] i_line,
    input  logic                         i_wr,
    input  logic [BURST_WIDTH-1:0]       i_beat,
    input  logic                         i_adv,
    output logic [$clog2(BEATS)-1:0]     o_cnt,
    output logic [BEATS*BURST_WIDTH-1:0] o_line,
    output logic [BURST_WIDTH-1:0]       o_slice
);
    localparam int CW = $clog2(BEATS);

    logic [BEATS-1:0][BURST_WIDTH-1:0] r_buf;
    logic [CW-1:0]                     r_cnt;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            if (i_load)
                r_buf <= i_line;
            else if (i_wr)
                r_buf[r_cnt] <= i_beat;
            // BEATS is a power of two, so the counter wraps naturally after the last beat
            if (i_clr)
                r_cnt <= '0;
            else if (i_adv)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_line  = r_buf;
    assign o_slice = r_buf[r_cnt];

endmodule

// File: rtl/pcs_cacheline_adapter.sv
// Splits 256-bit cache line transfers into 4-beat 64-bit memory bursts.
// Optional PCS_ADAPTER_EARLY_RESP_EN: read mem_resp in the cycle of the last beat.
module pcs_cacheline_adapter
    import pcs_cacheline_adapter_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = 256,
    parameter int BURST_WIDTH     = 64,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                    gclk,
    input  logic                    grst_n,
    pcs_cacheline_adapter_if.slave  bus
);
    localparam int BEATS = CACHE_LINE_SIZE / BURST_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int OFS_W = $clog2(CACHE_LINE_SIZE / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << OFS_W) - 64'd1);

    adapter_state_t              r_state, w_nxt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        w_clr, w_load, w_wr, w_adv, w_lat;
    logic                        w_resp, w_rd, w_bw, w_early;
    logic [CW-1:0]               w_cnt;
    logic [CACHE_LINE_SIZE-1:0]  w_line;
    logic [BURST_WIDTH-1:0]      w_slice;
    logic                        w_last;

    pcs_line_deser #(.BEATS(BEATS), .BURST_WIDTH(BURST_WIDTH)) u_deser (
        .gclk    (gclk),
        .grst_n  (grst_n),
        .i_clr   (w_clr),
        .i_load  (w_load),
        .i_line  (bus.mem_line_wb),
        .i_wr    (w_wr),
        .i_beat  (bus.bmem_rdata),
        .i_adv   (w_adv),
        .o_cnt   (w_cnt),
        .o_line  (w_line),
        .o_slice (w_slice)
    );

    assign w_last = (w_cnt == CW'(BEATS - 1));

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_lat)
                r_addr <= bus.mem_addr & ADDR_MASK;
        end
    end

    always_comb begin
        w_nxt   = r_state;
        w_clr   = 1'b0;
        w_load  = 1'b0;
        w_wr    = 1'b0;
        w_adv   = 1'b0;
        w_lat   = 1'b0;
        w_resp  = 1'b0;
        w_rd    = 1'b0;
        w_bw    = 1'b0;
        w_early = 1'b0;
        case (r_state)
            IDLE: begin
                // write has priority; a simultaneous read is dropped
                if (bus.mem_write) begin
                    w_load = 1'b1;
                    w_clr  = 1'b1;
                    w_lat  = 1'b1;
                    w_nxt  = WR_BURST;
                end else if (bus.mem_read) begin
                    w_clr = 1'b1;
                    w_lat = 1'b1;
                    w_nxt = RD_REQ;
                end
            end
            WR_BURST: begin
                w_bw = 1'b1;
                if (bus.bmem_ready) begin
                    w_adv = 1'b1;
                    if (w_last)
                        w_nxt = RESP;
                end
            end
            RD_REQ: begin
                w_rd = 1'b1;
                if (bus.bmem_ready)
                    w_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.bmem_rvalid) begin
                    w_wr  = 1'b1;
                    w_adv = 1'b1;
                    if (w_last) begin
`ifdef PCS_ADAPTER_EARLY_RESP_EN
                        w_resp  = 1'b1;
                        w_early = 1'b1;
                        w_nxt   = IDLE;
`else
                        w_nxt   = RESP;
`endif
                    end
                end
            end
            RESP: begin
                w_resp = 1'b1;
                w_nxt  = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign bus.mem_resp   = w_resp;
    assign bus.bmem_addr  = r_addr;
    assign bus.bmem_read  = w_rd;
    assign bus.bmem_write = w_bw;
    assign bus.bmem_wdata = w_bw ? w_slice : '0;

`ifdef PCS_ADAPTER_EARLY_RESP_EN
    // last beat bypasses the buffer so the line is complete in the rvalid cycle
    assign bus.mem_rdata = w_early ?
        {bus.bmem_rdata, w_line[CACHE_LINE_SIZE-BURST_WIDTH-1:0]} : w_line;
`else
    assign bus.mem_rdata = w_line;
`endif

    always_ff @(posedge gclk) begin
        if (grst_n && r_state == IDLE)
            assert (!(bus.mem_write && bus.mem_read))
            else $warning("pcs_cacheline_adapter: mem_read dropped, issued together with mem_write");
    end

endmodule
